// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the CPU-to-SDRAM half-word bridge.
package sdram_bridge_pkg;

  localparam int unsigned SLOT_CYCLES_DEF = 8;
  localparam int unsigned SLOT_CNT_W      = 6;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Latched CPU request (address is kept separately, its width is a parameter).
  typedef struct packed {
    logic        is_wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  // Byte enables for one half word: strobes on writes, both bytes on reads.
  function automatic logic [1:0] half_dqm(input req_t r, input logic half);
    if (!r.is_wr) return 2'b11;
    return (half == HALF_HI) ? r.wstrb[3:2] : r.wstrb[1:0];
  endfunction

  // Write data for one half word.
  function automatic logic [15:0] half_data(input req_t r, input logic half);
    return (half == HALF_HI) ? r.wdata[31:16] : r.wdata[15:0];
  endfunction

endpackage

// File: rtl/sdram_bridge_if.sv
// CPU native bus plus SDRAM controller slot signals seen by the bridge.
interface sdram_bridge_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              sel;
  logic [31:0]       addr;
  logic [3:0]        wstrb;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic [ADDR_W-1:0] sd_addr;
  logic              sd_we;
  logic              sd_oe;
  logic [1:0]        sd_dqm;
  logic [15:0]       sd_din;
  logic [15:0]       sd_dout;

  // Bridge side: consumes CPU requests and controller read data.
  modport slave (
    input  sel, addr, wstrb, wdata, sd_dout,
    output rdata, ready, sd_addr, sd_we, sd_oe, sd_dqm, sd_din
  );

  // Environment side: CPU plus controller.
  modport master (
    output sel, addr, wstrb, wdata, sd_dout,
    input  rdata, ready, sd_addr, sd_we, sd_oe, sd_dqm, sd_din
  );
endinterface

// File: rtl/sdram_slot_timer.sv
// Counts clk cycles within one controller slot; last flags the final cycle.
module sdram_slot_timer
  import sdram_bridge_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = SLOT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic last
);

  localparam logic [SLOT_CNT_W-1:0] CNT_MAX = SLOT_CNT_W'(SLOT_CYCLES - 1);

  logic [SLOT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  last_q, last_d;

  // Clear on slot entry, otherwise count up and hold at the final value.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = 1'b0;
    if (start) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + SLOT_CNT_W'(1);
    end
    last_d = (cnt_d == CNT_MAX);
  end

  // Counter and registered final-cycle flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign last = last_q;

endmodule

// File: rtl/sdram_bridge.sv
// Splits 32-bit CPU accesses into one or two fixed-length 16-bit SDRAM slots.
module sdram_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned SLOT_CYCLES = SLOT_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           reset,
  sdram_bridge_if.slave  bus
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
  logic              sd_we_q, sd_we_d;
  logic              sd_oe_q, sd_oe_d;
  logic [1:0]        sd_dqm_q, sd_dqm_d;
  logic [15:0]       sd_din_q, sd_din_d;

  logic              slot_start_c;
  logic              slot_last;
  logic              half_c;
  logic              unused_addr_c;

  // Word-aligned address bits beyond the controller range are dropped.
  assign unused_addr_c = ^{bus.addr[31:ADDR_W], bus.addr[1:0]};

  sdram_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_slot_timer (
    .clk   (clk),
    .reset (reset),
    .start (slot_start_c),
    .last  (slot_last)
  );

  // Next state, request latch, read capture and next values of the slot outputs.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    sd_addr_d = sd_addr_q;
    sd_din_d  = sd_din_q;
    sd_we_d   = 1'b0;
    sd_oe_d   = 1'b0;
    sd_dqm_d  = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (bus.sel) begin
          addr_d      = bus.addr[ADDR_W-1:2];
          req_d.is_wr = |bus.wstrb;
          req_d.wstrb = bus.wstrb;
          req_d.wdata = bus.wdata;
          state_d     = (|bus.wstrb && bus.wstrb[1:0] == 2'b00) ? HI : LO;
        end
      end
      LO: begin
        if (slot_last) begin
          if (!req_q.is_wr) rdata_d[15:0] = bus.sd_dout;
          state_d = (req_q.is_wr && req_q.wstrb[3:2] == 2'b00) ? DONE : HI;
        end
      end
      HI: begin
        if (slot_last) begin
          if (!req_q.is_wr) rdata_d[31:16] = bus.sd_dout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Slot outputs follow the state being entered so they line up with it.
    slot_start_c = (state_d == LO || state_d == HI) && (state_d != state_q);
    half_c       = (state_d == HI) ? HALF_HI : HALF_LO;
    ready_d      = (state_d == DONE);
    if (state_d == LO || state_d == HI) begin
      sd_addr_d = {addr_d, half_c, 1'b0};
      sd_din_d  = half_data(req_d, half_c);
      sd_dqm_d  = half_dqm(req_d, half_c);
      sd_we_d   = req_d.is_wr;
      sd_oe_d   = !req_d.is_wr;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      sd_addr_q <= '0;
      sd_we_q   <= 1'b0;
      sd_oe_q   <= 1'b0;
      sd_dqm_q  <= 2'b00;
      sd_din_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      sd_addr_q <= sd_addr_d;
      sd_we_q   <= sd_we_d;
      sd_oe_q   <= sd_oe_d;
      sd_dqm_q  <= sd_dqm_d;
      sd_din_q  <= sd_din_d;
    end
  end

  assign bus.rdata   = rdata_q;
  assign bus.ready   = ready_q;
  assign bus.sd_addr = sd_addr_q;
  assign bus.sd_we   = sd_we_q;
  assign bus.sd_oe   = sd_oe_q;
  assign bus.sd_dqm  = sd_dqm_q;
  assign bus.sd_din  = sd_din_q;

endmodule
